// File: rtl/int_arith_pkg.sv
// Shared definitions for the sequential integer arithmetic units
// (multiplier and divider): FSM state encoding and counter sizing.
package int_arith_pkg;

  typedef enum logic [1:0] {
    idle_s,
    calc_s
  } arith_fsm_t;

  // Bits needed for an iteration counter that must hold the value w.
  function automatic int arith_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/int_multiplier_if.sv
// Start/ready handshake bundle for int_multiplier.
//   cal     : start request (master -> slave)
//   mpd/mpr : multiplicand / multiplier, unsigned, WIDTH bits
//   prd     : 2*WIDTH-bit product, held until the next completion
//   ovf     : product does not fit in WIDTH bits
//   rdy     : unit idle with a valid result (gated by cal)
interface int_multiplier_if #(
  parameter int WIDTH = 12
);
  logic               cal;
  logic [WIDTH-1:0]   mpd;
  logic [WIDTH-1:0]   mpr;
  logic [2*WIDTH-1:0] prd;
  logic               ovf;
  logic               rdy;

  modport master (output cal, mpd, mpr, input prd, ovf, rdy);
  modport slave  (input cal, mpd, mpr, output prd, ovf, rdy);
endinterface

// File: rtl/int_multiplier.sv
// Sequential radix-2 shift-add unsigned multiplier.
// One multiplier bit is consumed per clock; the full 2*WIDTH product and
// an overflow flag (high half non-zero) are registered on completion.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (aborts any operation)
//   bus   : int_multiplier_if slave (cal, mpd, mpr, prd, ovf, rdy)
// Parameters:
//   WIDTH      : operand width (>= 2)
//   EARLY_EXIT : 1 = stop once the remaining multiplier bits are zero
module int_multiplier
  import int_arith_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  int_multiplier_if.slave   bus
);

  localparam int CW = arith_cnt_w(WIDTH);

  arith_fsm_t           fsm_q;
  logic [2*WIDTH-1:0]   acc_q,   acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q,  mplr_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [2*WIDTH-1:0]   prd_q;
  logic                 ovf_q;
  logic                 rdy_q;
  logic                 last_iter;

  // One shift-add iteration; last_iter covers both the fixed count and
  // the early exit when no set multiplier bits remain.
  always_comb begin
    acc_d     = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d   = mcand_q << 1;
    mplr_d    = mplr_q >> 1;
    cnt_d     = cnt_q + CW'(1);
    last_iter = (cnt_q == CW'(WIDTH - 1)) || (EARLY_EXIT && (mplr_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= idle_s;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      prd_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (fsm_q)
        idle_s: begin
          if (bus.cal) begin
            rdy_q   <= 1'b0;
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, bus.mpd};
            mplr_q  <= bus.mpr;
            cnt_q   <= '0;
            fsm_q   <= calc_s;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        calc_s: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_d;
          if (last_iter) begin
            prd_q <= acc_d;
            ovf_q <= |acc_d[2*WIDTH-1:WIDTH];
            rdy_q <= 1'b1;
            fsm_q <= idle_s;
          end
        end
        default: fsm_q <= idle_s;
      endcase
    end
  end

  assign bus.prd = prd_q;
  assign bus.ovf = ovf_q;
  assign bus.rdy = rdy_q && !bus.cal;

endmodule

// File: tb/tb_int_multiplier.sv
// Directed and random checks of int_multiplier in four configurations:
//   0: WIDTH=12 fixed latency   1: WIDTH=12 early exit
//   2: WIDTH=16 fixed latency   3: WIDTH=16 early exit
module tb_int_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cal_a [4];
  logic [15:0] mpd_a [4];
  logic [15:0] mpr_a [4];
  logic [31:0] prd_a [4];
  logic        ovf_a [4];
  logic        rdy_a [4];

  logic [31:0] last_exp [4];
  logic        last_ovf [4];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  int_multiplier_if #(.WIDTH(12)) if0 ();
  int_multiplier_if #(.WIDTH(12)) if1 ();
  int_multiplier_if #(.WIDTH(16)) if2 ();
  int_multiplier_if #(.WIDTH(16)) if3 ();

  int_multiplier #(.WIDTH(12), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  int_multiplier #(.WIDTH(12), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  int_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  int_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.cal = cal_a[0];  assign if0.mpd = mpd_a[0][11:0];  assign if0.mpr = mpr_a[0][11:0];
  assign if1.cal = cal_a[1];  assign if1.mpd = mpd_a[1][11:0];  assign if1.mpr = mpr_a[1][11:0];
  assign if2.cal = cal_a[2];  assign if2.mpd = mpd_a[2];        assign if2.mpr = mpr_a[2];
  assign if3.cal = cal_a[3];  assign if3.mpd = mpd_a[3];        assign if3.mpr = mpr_a[3];

  assign prd_a[0] = {8'h00, if0.prd};  assign ovf_a[0] = if0.ovf;  assign rdy_a[0] = if0.rdy;
  assign prd_a[1] = {8'h00, if1.prd};  assign ovf_a[1] = if1.ovf;  assign rdy_a[1] = if1.rdy;
  assign prd_a[2] = if2.prd;           assign ovf_a[2] = if2.ovf;  assign rdy_a[2] = if2.rdy;
  assign prd_a[3] = if3.prd;           assign ovf_a[3] = if3.ovf;  assign rdy_a[3] = if3.rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int cfg_w(input int d);
    return (d < 2) ? 12 : 16;
  endfunction

  function automatic logic [31:0] mul_ref(input int d, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] am, bm;
    am = {16'h0000, a};
    bm = {16'h0000, b};
    if (d < 2) begin
      am[15:12] = 4'h0;
      bm[15:12] = 4'h0;
    end
    return am * bm;
  endfunction

  function automatic logic ovf_ref(input int d, input logic [31:0] p);
    return (d < 2) ? (p[31:12] != 20'h0) : (p[31:16] != 16'h0);
  endfunction

  function automatic int lat_ref(input int d, input logic [15:0] b);
    int hi;
    if ((d % 2) == 0) return cfg_w(d);
    hi = 0;
    for (int i = 0; i < cfg_w(d); i++)
      if (b[i]) hi = i + 1;
    return (hi < 1) ? 1 : hi;
  endfunction

  // Start one operation on unit d and follow it to completion. Operands are
  // scrambled right after the start edge to show they were captured.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input logic exp_o, input int exp_lat,
                        input string tag);
    int n;
    n = 0;
    while (!rdy_a[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/idle_rdy"}, 32'(rdy_a[d]), 32'd1);
    @(negedge clk);
    cal_a[d] = 1'b1;
    mpd_a[d] = a;
    mpr_a[d] = b;
    @(posedge clk);
    @(negedge clk);
    cal_a[d] = 1'b0;
    mpd_a[d] = ~a;
    mpr_a[d] = ~b;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!rdy_a[d]) begin
        check({tag, "/hold_prd"}, prd_a[d], last_exp[d]);
        check({tag, "/hold_ovf"}, 32'(ovf_a[d]), 32'(last_ovf[d]));
      end
    end while (!rdy_a[d] && n < 40);
    check({tag, "/latency"}, 32'(n), 32'(exp_lat));
    check({tag, "/prd"}, prd_a[d], exp_p);
    check({tag, "/ovf"}, 32'(ovf_a[d]), 32'(exp_o));
    last_exp[d] = exp_p;
    last_ovf[d] = exp_o;
  endtask

  task automatic run_rand(input int d);
    logic [15:0] a, b;
    logic [31:0] p;
    a = 16'($urandom);
    b = 16'($urandom);
    p = mul_ref(d, a, b);
    run_op(d, a, b, p, ovf_ref(d, p), lat_ref(d, b), "rand");
  endtask

  // cal held high: back-to-back operations every WIDTH+1 edges, each using
  // the operands present on its own start edge.
  task automatic hold_cal_test();
    logic [11:0] ha [39];
    logic [11:0] hb [39];
    logic [31:0] ep;
    logic        eo;
    int n;
    for (int c = 0; c < 39; c++) begin
      ha[c] = 12'($urandom);
      hb[c] = 12'($urandom);
    end
    n = 0;
    while (!rdy_a[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ep = last_exp[0];
    eo = last_ovf[0];
    for (int c = 0; c < 39; c++) begin
      @(negedge clk);
      cal_a[0] = 1'b1;
      mpd_a[0] = {4'h0, ha[c]};
      mpr_a[0] = {4'h0, hb[c]};
      @(posedge clk); #1;
      if ((c % 13) == 12) begin
        ep = 32'(ha[c-12]) * 32'(hb[c-12]);
        eo = (ep[31:12] != 20'h0);
      end
      check("holdcal/rdy", 32'(rdy_a[0]), 32'd0);
      check("holdcal/prd", prd_a[0], ep);
      check("holdcal/ovf", 32'(ovf_a[0]), 32'(eo));
    end
    @(negedge clk);
    cal_a[0] = 1'b0;
    last_exp[0] = ep;
    last_ovf[0] = eo;
    @(posedge clk); #1;
    check("holdcal/rdy_after", 32'(rdy_a[0]), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      cal_a[d] = 1'b0;
      mpd_a[d] = '0;
      mpr_a[d] = '0;
      last_exp[d] = '0;
      last_ovf[d] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("reset/prd", prd_a[d], 32'd0);
      check("reset/ovf", 32'(ovf_a[d]), 32'd0);
      check("reset/rdy", 32'(rdy_a[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++)
      check("reset/rdy_first_edge", 32'(rdy_a[d]), 32'd1);

    run_op(0, 16'd37,   16'd100,  32'd3700,      1'b0, 12, "w12/37x100");
    run_op(0, 16'd4095, 16'd4095, 32'd16769025,  1'b1, 12, "w12/max");
    run_op(0, 16'd0,    16'd4095, 32'd0,         1'b0, 12, "w12/zero_mpd");
    run_op(1, 16'd5,    16'd1,    32'd5,         1'b0, 1,  "w12ee/5x1");
    run_op(1, 16'd3,    16'h0800, 32'd6144,      1'b1, 12, "w12ee/3x800");
    run_op(1, 16'd4095, 16'd0,    32'd0,         1'b0, 1,  "w12ee/zero_mpr");
    run_op(1, 16'd37,   16'd100,  32'd3700,      1'b0, 7,  "w12ee/37x100");
    run_op(2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,  1'b1, 16, "w16/max");
    run_op(2, 16'd37,   16'd100,  32'd3700,      1'b0, 16, "w16/37x100");
    run_op(3, 16'hFFFF, 16'h8000, 32'h7FFF8000,  1'b1, 16, "w16ee/topbit");
    run_op(3, 16'd1234, 16'd3,    32'd3702,      1'b0, 2,  "w16ee/1234x3");

    hold_cal_test();

    // Asynchronous reset in the middle of an operation (cnt=5).
    run_op(0, 16'd37, 16'd100, 32'd3700, 1'b0, 12, "prerst");
    @(negedge clk);
    cal_a[0] = 1'b1;
    mpd_a[0] = 16'd55;
    mpr_a[0] = 16'd66;
    @(posedge clk);
    @(negedge clk);
    cal_a[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst/prd", prd_a[0], 32'd0);
    check("midrst/ovf", 32'(ovf_a[0]), 32'd0);
    check("midrst/rdy", 32'(rdy_a[0]), 32'd0);
    check("midrst/other_prd", prd_a[3], 32'd0);
    for (int d = 0; d < 4; d++) begin
      last_exp[d] = '0;
      last_ovf[d] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst/rdy_release", 32'(rdy_a[0]), 32'd1);
    run_op(0, 16'd7, 16'd9, 32'd63, 1'b0, 12, "midrst/7x9");

    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 250; k++)
        run_rand(d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
